// File: rtl/bbg_pkg.sv
// Shared types and constants for the baseband-generator run-time sequencer.
package bbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } bbg_state_t;

    // Field order matches the cfg_wdata word {dwell, freq, pn, syb}.
    typedef struct packed {
        logic [15:0] dwell;
        logic [7:0]  freq;
        logic [2:0]  pn;
        logic [1:0]  syb;
    } bbg_prof_t;

    localparam int PROF_W = $bits(bbg_prof_t);

    localparam logic [1:0] SYB_BPSK  = 2'd0;
    localparam logic [1:0] SYB_QPSK  = 2'd1;
    localparam logic [1:0] SYB_16QAM = 2'd2;
    localparam logic [1:0] SYB_64QAM = 2'd3;

    localparam logic [2:0] PN3  = 3'd0;
    localparam logic [2:0] PN5  = 3'd1;
    localparam logic [2:0] PN7  = 3'd2;
    localparam logic [2:0] PN9  = 3'd3;
    localparam logic [2:0] PN11 = 3'd4;
    localparam logic [2:0] PN15 = 3'd5;

    function automatic logic prof_skipped(input bbg_prof_t p);
        return (p.dwell == 16'd0);
    endfunction

endpackage

// File: rtl/bbg_prof_regs.sv
// Profile table: NPROF entries, one write port, combinational read by index.
module bbg_prof_regs
    import bbg_pkg::*;
#(
    parameter  int NPROF = 4,
    localparam int AW    = $clog2(NPROF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  bbg_prof_t       wdata,
    input  logic [AW-1:0]   raddr,
    output bbg_prof_t       rdata
);

    bbg_prof_t table_q [NPROF];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPROF; i++) table_q[i] <= '0;
        end else if (we) begin
            table_q[waddr] <= wdata;
        end
    end

    assign rdata = table_q[raddr];

endmodule

// File: rtl/bbg_seq.sv
// Run-time sequencer: steps through the profile table on PRBS pattern boundaries,
// flushing the filter chain and muting the DAC path around every profile change.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for start; generator disabled, outputs muted
//   ST_LOAD  | one cycle per entry: skip dwell==0 or latch freq/pn/syb
//   ST_FLUSH | flt_clr held for FLUSH_LEN cycles, generator disabled
//   ST_RUN   | generator on; unmute after SETTLE cke; count pattern edges
module bbg_seq
    import bbg_pkg::*;
#(
    parameter  int NPROF     = 4,
    parameter  int FLUSH_LEN = 4,
    parameter  int SETTLE    = 48,
    localparam int AW        = $clog2(NPROF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            loop,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [28:0]     cfg_wdata,
    input  logic            cke,
    input  logic            pat_sync,
    output logic [7:0]      freq,
    output logic [2:0]      pn,
    output logic [1:0]      syb,
    output logic            gen_en,
    output logic            flt_clr,
    output logic            mute,
    output logic            busy,
    output logic [AW-1:0]   prof_idx,
    output logic            done
);

    localparam int FW = $clog2(FLUSH_LEN + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [AW-1:0] LAST       = AW'(NPROF - 1);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_LEN - 1);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE);

    bbg_state_t      state, state_nx;
    logic [AW-1:0]   idx, idx_nx;
    logic [AW-1:0]   skip_cnt, skip_nx;
    logic [FW-1:0]   flush_cnt;
    logic [SW-1:0]   settle_cnt;
    logic [15:0]     dwell_cnt;
    logic            stop_pend;
    logic            pat_prev;
    logic            pat_rise;
    logic            latch;
    logic            to_idle;
    logic            done_q;
    logic [7:0]      freq_q;
    logic [2:0]      pn_q;
    logic [1:0]      syb_q;
    bbg_prof_t       prof_rd;

    bbg_prof_regs #(.NPROF(NPROF)) u_regs (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (bbg_prof_t'(cfg_wdata)),
        .raddr (idx),
        .rdata (prof_rd)
    );

    assign pat_rise = pat_sync & ~pat_prev;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        skip_nx  = skip_cnt;
        latch    = 1'b0;
        to_idle  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nx = ST_LOAD;
                    idx_nx   = '0;
                    skip_nx  = '0;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    to_idle = 1'b1;
                end else if (prof_skipped(prof_rd)) begin
                    // Without loop, skipping past the last entry ends the table.
                    if (skip_cnt == LAST || (idx == LAST && !loop)) begin
                        to_idle = 1'b1;
                    end else begin
                        idx_nx  = idx + 1'b1;
                        skip_nx = skip_cnt + 1'b1;
                    end
                end else begin
                    latch    = 1'b1;
                    state_nx = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (stop) to_idle = 1'b1;
                else if (flush_cnt == '0) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (pat_rise && (stop_pend || stop || dwell_cnt == 16'd1)) begin
                    if (stop_pend || stop || (idx == LAST && !loop)) begin
                        to_idle = 1'b1;
                    end else begin
                        state_nx = ST_LOAD;
                        idx_nx   = idx + 1'b1;
                        skip_nx  = '0;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (to_idle) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            skip_cnt   <= '0;
            flush_cnt  <= FLUSH_INIT;
            settle_cnt <= SETTLE_INIT;
            dwell_cnt  <= '0;
            stop_pend  <= 1'b0;
            pat_prev   <= 1'b0;
            done_q     <= 1'b0;
            freq_q     <= '0;
            pn_q       <= '0;
            syb_q      <= '0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            skip_cnt <= skip_nx;
            pat_prev <= pat_sync;
            done_q   <= to_idle;

            if (latch) begin
                freq_q    <= prof_rd.freq;
                pn_q      <= prof_rd.pn;
                syb_q     <= prof_rd.syb;
                dwell_cnt <= prof_rd.dwell;
            end else if (state == ST_RUN && pat_rise && dwell_cnt != '0) begin
                dwell_cnt <= dwell_cnt - 1'b1;
            end

            if (state != ST_FLUSH) flush_cnt <= FLUSH_INIT;
            else if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;

            if (state != ST_RUN) settle_cnt <= SETTLE_INIT;
            else if (cke && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;

            if (state != ST_RUN) stop_pend <= 1'b0;
            else if (stop) stop_pend <= 1'b1;
        end
    end

    assign freq     = freq_q;
    assign pn       = pn_q;
    assign syb      = syb_q;
    assign gen_en   = (state == ST_RUN);
    assign flt_clr  = (state == ST_FLUSH);
    assign mute     = !(state == ST_RUN && settle_cnt == '0);
    assign busy     = (state != ST_IDLE);
    assign prof_idx = idx;
    assign done     = done_q;

endmodule

// File: tb/tb_bbg_seq.sv
// Directed self-checking bench for bbg_seq; status word is {busy,gen_en,flt_clr,mute,done}.
module tb_bbg_seq;
    import bbg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, stop = 1'b0, loop = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [28:0] cfg_wdata = '0;
    logic        cke = 1'b0, pat_sync = 1'b0;
    logic [7:0]  freq;
    logic [2:0]  pn;
    logic [1:0]  syb;
    logic        gen_en, flt_clr, mute, busy, done;
    logic [1:0]  prof_idx;

    int vecs = 0;
    int errs = 0;

    wire [4:0] st = {busy, gen_en, flt_clr, mute, done};

    bbg_seq #(.NPROF(4), .FLUSH_LEN(4), .SETTLE(48)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cke(cke), .pat_sync(pat_sync),
        .freq(freq), .pn(pn), .syb(syb), .gen_en(gen_en), .flt_clr(flt_clr),
        .mute(mute), .busy(busy), .prof_idx(prof_idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [7:0] f,
                      input logic [2:0] p, input logic [1:0] s);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = {d, f, p, s};
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pat_edge();
        pat_sync = 1'b1; tick(); pat_sync = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (!gen_en && n < 12) begin tick(); n++; end
        vecs++;
        if (gen_en !== 1'b1) begin
            errs++; $display("FAIL %s_run_timeout gen_en=%b required 1", tag, gen_en);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        vecs++;
        if (st !== 5'b00010) begin
            errs++; $display("FAIL reset_status got %b required 00010", st);
        end
        vecs++;
        if ({freq, pn, syb, prof_idx} !== 15'd0) begin
            errs++; $display("FAIL reset_cfg got %h required 0", {freq, pn, syb, prof_idx});
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        loop = 1'b0;
        wr(2'd0, 16'd2, 8'h5A, PN7, SYB_QPSK);
        pulse_start();
        vecs++;
        if (st !== 5'b10010) begin errs++; $display("FAIL basic_load got %b required 10010", st); end
        tick();
        vecs++;
        if (st !== 5'b10110) begin errs++; $display("FAIL basic_flush got %b required 10110", st); end
        vecs++;
        if ({freq, pn, syb} !== {8'h5A, PN7, SYB_QPSK}) begin
            errs++; $display("FAIL basic_cfg got %h required %h", {freq, pn, syb}, {8'h5A, PN7, SYB_QPSK});
        end
        n = 0;
        while (flt_clr && n < 20) begin n++; tick(); end
        vecs++;
        if (n !== 4) begin errs++; $display("FAIL basic_flush_len got %0d required 4", n); end
        vecs++;
        if (st !== 5'b11010) begin errs++; $display("FAIL basic_run got %b required 11010", st); end
        cke = 1'b1;
        tick(47);
        vecs++;
        if (mute !== 1'b1) begin errs++; $display("FAIL basic_mute47 got %b required 1", mute); end
        tick();
        cke = 1'b0;
        vecs++;
        if (st !== 5'b11000) begin errs++; $display("FAIL basic_unmute got %b required 11000", st); end
        tick(3);
        pat_edge();
        vecs++;
        if (st !== 5'b11000) begin errs++; $display("FAIL basic_edge1 got %b required 11000", st); end
        tick(2);
        pat_edge();
        vecs++;
        if (st !== 5'b10010) begin errs++; $display("FAIL basic_edge2 got %b required 10010", st); end
        // entries 1..3 have dwell 0 and are skipped one LOAD cycle each
        tick(3);
        vecs++;
        if (st !== 5'b00011) begin errs++; $display("FAIL basic_done got %b required 00011", st); end
        tick();
        vecs++;
        if (st !== 5'b00010) begin errs++; $display("FAIL basic_done_pulse got %b required 00010", st); end
    endtask

    task automatic test_seq_wrap();
        logic [1:0] exp_syb [4];
        logic [1:0] exp_idx [4];
        logic [7:0] exp_frq [4];
        int n;
        exp_syb = '{SYB_BPSK, SYB_16QAM, SYB_64QAM, SYB_BPSK};
        exp_idx = '{2'd0, 2'd2, 2'd3, 2'd0};
        exp_frq = '{8'h11, 8'h22, 8'h33, 8'h11};
        wr(2'd0, 16'd1, 8'h11, PN3, SYB_BPSK);
        wr(2'd1, 16'd0, 8'hEE, PN15, SYB_QPSK);
        wr(2'd2, 16'd1, 8'h22, PN9, SYB_16QAM);
        wr(2'd3, 16'd1, 8'h33, PN11, SYB_64QAM);
        loop = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!flt_clr && n < 8) begin tick(); n++; end
            vecs++;
            if (flt_clr !== 1'b1) begin errs++; $display("FAIL seq%0d_flush_timeout flt_clr=%b required 1", i, flt_clr); end
            vecs++;
            if ({prof_idx, freq, syb} !== {exp_idx[i], exp_frq[i], exp_syb[i]}) begin
                errs++; $display("FAIL seq%0d_profile got %h required %h", i,
                                 {prof_idx, freq, syb}, {exp_idx[i], exp_frq[i], exp_syb[i]});
            end
            n = 0;
            while (flt_clr && n < 20) begin n++; tick(); end
            vecs++;
            if ({n[3:0], gen_en} !== {4'd4, 1'b1}) begin
                errs++; $display("FAIL seq%0d_burst len=%0d gen_en=%b required 4/1", i, n, gen_en);
            end
            if (i == 3) begin
                stop = 1'b1; tick(); stop = 1'b0;
                tick();
            end
            pat_edge();
        end
        vecs++;
        if (st !== 5'b00011) begin errs++; $display("FAIL seq_stop_done got %b required 00011", st); end
        tick();
    endtask

    task automatic test_stop();
        loop = 1'b0;
        wr(2'd0, 16'd100, 8'h77, PN5, SYB_QPSK);
        pulse_start();
        wait_run("stop");
        stop = 1'b1; tick(); stop = 1'b0;
        vecs++;
        if (st !== 5'b11010) begin errs++; $display("FAIL stop_pending got %b required 11010", st); end
        tick(3);
        pat_edge();
        vecs++;
        if (st !== 5'b00011) begin errs++; $display("FAIL stop_run got %b required 00011", st); end
        tick();
        pulse_start();
        tick();
        vecs++;
        if (st !== 5'b10110) begin errs++; $display("FAIL stop_in_flush_pre got %b required 10110", st); end
        stop = 1'b1; tick(); stop = 1'b0;
        vecs++;
        if (st !== 5'b00011) begin errs++; $display("FAIL stop_flush got %b required 00011", st); end
        tick();
    endtask

    task automatic test_all_zero();
        int n;
        logic g;
        for (int a = 0; a < 4; a++) wr(2'(a), 16'd0, 8'hA5, PN3, SYB_BPSK);
        loop = 1'b1;
        pulse_start();
        n = 0; g = 1'b0;
        while (busy && n < 10) begin
            if (gen_en) g = 1'b1;
            tick(); n++;
        end
        vecs++;
        if (n !== 4) begin errs++; $display("FAIL zero_load_cycles got %0d required 4", n); end
        vecs++;
        if ({g, done} !== 2'b01) begin errs++; $display("FAIL zero_done gen_seen/done got %b required 01", {g, done}); end
        tick();
    endtask

    task automatic test_write_run();
        loop = 1'b0;
        wr(2'd0, 16'd2, 8'h40, PN3, SYB_QPSK);
        pulse_start();
        wait_run("wrun");
        wr(2'd0, 16'd1, 8'h99, PN15, SYB_64QAM);
        vecs++;
        if ({gen_en, freq, pn, syb} !== {1'b1, 8'h40, PN3, SYB_QPSK}) begin
            errs++; $display("FAIL wrun_hold got %h required %h", {gen_en, freq, pn, syb}, {1'b1, 8'h40, PN3, SYB_QPSK});
        end
        tick();
        pat_edge();
        tick();
        pat_edge();
        tick(4);
        vecs++;
        if (busy !== 1'b0) begin errs++; $display("FAIL wrun_end busy=%b required 0", busy); end
        pulse_start();
        tick();
        vecs++;
        if ({flt_clr, freq, pn, syb} !== {1'b1, 8'h99, PN15, SYB_64QAM}) begin
            errs++; $display("FAIL wrun_reload got %h required %h", {flt_clr, freq, pn, syb}, {1'b1, 8'h99, PN15, SYB_64QAM});
        end
        stop = 1'b1; tick(); stop = 1'b0;
        tick();
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        vecs++;
        if (st !== 5'b00010) begin errs++; $display("FAIL start_stop_idle got %b required 00010", st); end
        tick();
        vecs++;
        if (st !== 5'b00010) begin errs++; $display("FAIL start_stop_idle2 got %b required 00010", st); end
    endtask

    task automatic test_reset_flush();
        pulse_start();
        tick(2);
        vecs++;
        if (flt_clr !== 1'b1) begin errs++; $display("FAIL rflush_pre flt_clr=%b required 1", flt_clr); end
        #2 rst = 1'b0;
        #1;
        vecs++;
        if (st !== 5'b00010) begin errs++; $display("FAIL rflush_async got %b required 00010", st); end
        vecs++;
        if ({freq, pn, syb, prof_idx} !== 15'd0) begin
            errs++; $display("FAIL rflush_cfg got %h required 0", {freq, pn, syb, prof_idx});
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seq_wrap();
        test_stop();
        test_all_zero();
        test_write_run();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
